ux607_jtag_tap_ctrl: RTL and testbench
======================================

Name: ux607_jtag_tap_ctrl

Overview:
IEEE 1149.1 TAP controller for the JTAG GPIO pin port, running on the system clock.
- Oversamples the port's TCK/TMS/TDI/TRST outputs.
- Sequences the 16-state TAP FSM and holds the IR plus IDCODE/BYPASS/USER data registers.
- Drives TDO and the TDO pad output enable back into the port.
- The USER DR exposes capture/update handshakes to a downstream debug transport module.

Parameters:
IR_W, 5, instruction register width
IDCODE_VAL, 32'h1E200A6D, value captured by IDCODE DR (bit0 must be 1)
IR_IDCODE, 5'h01, IDCODE opcode (also IR reset value)
IR_USER, 5'h10, USER DR opcode
USER_W, 32, USER DR width
SYNC_STAGES, 2, synchronizer depth on TCK/TMS/TDI/TRST

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
jtag_tck  in  1  TCK from pin port (asynchronous)
jtag_tms  in  1  TMS from pin port
jtag_tdi  in  1  TDI from pin port
jtag_trst  in  1  TRST, active-high (already inverted by the port)
jtag_tdo  out  1  TDO to pin port oval
jtag_drv_tdo  out  1  TDO output enable to pin port
tap_state  out  4  current TAP state encoding
ir_q  out  IR_W  current instruction
user_capture  out  1  one-clock pulse: USER DR captured
user_capture_data  in  USER_W  value loaded in Capture-DR when IR==IR_USER
user_update  out  1  one-clock pulse: USER DR updated
user_update_data  out  USER_W  shift register contents, valid while user_update=1

Behaviour:
- Reset values (rst_n=0): tap_state=Test-Logic-Reset (4'hF); ir_q=IR_IDCODE; jtag_tdo=0; jtag_drv_tdo=0; user_capture=0; user_update=0; all shift registers 0; synchronizers 0.
- Synchronization:
  - All four inputs pass through SYNC_STAGES flops, then one history flop on TCK.
  - Rise event: sync=1 and hist=0. Fall event: sync=0 and hist=1. Each event is a single-clock strobe.
  - Latency from pin edge to event is SYNC_STAGES+1 clocks.
  - Legal only if TCK high and low each last ≥ 3 clock periods; otherwise behaviour is undefined.
- TRST: synchronized jtag_trst=1 forces Test-Logic-Reset and ir_q=IR_IDCODE on the next clock, and holds them there; TCK events are ignored while it is asserted.
- FSM:
  - Advances only on rise events, using synchronized TMS, per the standard 16-state graph.
  - Encoding: TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
  - Five rise events with TMS=1 reach TLR from any state.
  - Entering TLR also loads ir_q=IR_IDCODE.
- Register actions on a rise event, based on the state before the transition:
  - CapIR: ir_shift = {IR_W-2 zeros, 2'b01}.
  - ShIR: ir_shift = {tdi, ir_shift[IR_W-1:1]}, LSB first.
  - CapDR: selected DR loaded — IDCODE gets IDCODE_VAL; BYPASS gets 0; USER gets user_capture_data, and user_capture pulses in that same clock.
  - ShDR: selected DR shifts right, TDI entering the MSB. BYPASS is 1 bit.
- DR select: IR_IDCODE → IDCODE; IR_USER → USER; every other opcode (including all-ones) → BYPASS.
- Update actions on a fall event while in an update state:
  - UpdIR: ir_q = ir_shift.
  - UpdDR with ir_q==IR_USER: user_update_data = user_shift, and user_update pulses for one clock.
- TDO timing:
  - On each fall event, jtag_tdo = LSB of the active shift register (ir_shift in ShIR, selected DR in ShDR); it holds otherwise.
  - On the same fall event, jtag_drv_tdo = 1 if state is ShIR/ShDR, else 0.
- Simultaneous TRST and TCK event: TRST wins.
- Reset mid-shift discards partial data; no update pulse is emitted.

Decomposition:
- Package ux607_jtag_pkg holds:
  - the TAP state localparams (encodings above);
  - default opcodes IR_IDCODE, IR_USER and IR_BYPASS=all-ones;
  - IDCODE_VAL default.
- One sub-module, ux607_jtag_sync: parameterized N-stage synchronizer with async active-low reset, instantiated four times.
- FSM, IR and DRs stay in the top module.

Test Plan:
- Reset then IR-read: 5 TMS=1 clocks, then TMS 0,1,1,0,0 to ShIR; shift 5 bits of TDI=1 → TDO sequence 1,0,0,0,0 with jtag_drv_tdo=1 only during the shift. Exit and update → ir_q=5'h1F (BYPASS).
- IDCODE read after reset: go to ShDR and shift 32 bits → TDO LSB-first equals 32'h1E200A6D.
- BYPASS: IR=5'h1F, shift TDI pattern 1,0,1,1 through DR → TDO is the same pattern delayed one TCK, with leading 0.
- USER DR:
  - IR=5'h10 with user_capture_data=32'hA5A5_0F0F: CapDR → one user_capture pulse.
  - Shift 32 bits of 32'h1234_5678 → TDO emits 32'hA5A50F0F.
  - UpdDR → user_update pulses once with user_update_data=32'h1234_5678.
- TRST mid-ShDR: assert jtag_trst during a USER shift → tap_state=4'hF and ir_q=5'h01 within SYNC_STAGES+2 clocks; no user_update; jtag_drv_tdo returns to 0 on the next fall event.
- Async reset: drop rst_n mid-ShIR → all outputs return to reset values immediately, without a clock.

Source files
------------

// File: rtl/ux607_jtag_pkg.sv
// Shared TAP encodings, default opcodes and the IEEE 1149.1 next-state function
// for the oversampled JTAG TAP controller.
package ux607_jtag_pkg;

    typedef enum logic [3:0] {
        TAP_EX2DR   = 4'h0,
        TAP_EX1DR   = 4'h1,
        TAP_SHDR    = 4'h2,
        TAP_PAUSEDR = 4'h3,
        TAP_SELIR   = 4'h4,
        TAP_UPDDR   = 4'h5,
        TAP_CAPDR   = 4'h6,
        TAP_SELDR   = 4'h7,
        TAP_EX2IR   = 4'h8,
        TAP_EX1IR   = 4'h9,
        TAP_SHIR    = 4'hA,
        TAP_PAUSEIR = 4'hB,
        TAP_RTI     = 4'hC,
        TAP_UPDIR   = 4'hD,
        TAP_CAPIR   = 4'hE,
        TAP_TLR     = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER
    } dr_sel_e;

    localparam logic [4:0]  JTAG_IR_IDCODE  = 5'h01;
    localparam logic [4:0]  JTAG_IR_USER    = 5'h10;
    localparam logic [4:0]  JTAG_IR_BYPASS  = 5'h1F;
    localparam logic [31:0] JTAG_IDCODE_VAL = 32'h1E20_0A6D;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        n = TAP_TLR;
        case (s)
            TAP_TLR:     n = tms ? TAP_TLR     : TAP_RTI;
            TAP_RTI:     n = tms ? TAP_SELDR   : TAP_RTI;
            TAP_SELDR:   n = tms ? TAP_SELIR   : TAP_CAPDR;
            TAP_CAPDR:   n = tms ? TAP_EX1DR   : TAP_SHDR;
            TAP_SHDR:    n = tms ? TAP_EX1DR   : TAP_SHDR;
            TAP_EX1DR:   n = tms ? TAP_UPDDR   : TAP_PAUSEDR;
            TAP_PAUSEDR: n = tms ? TAP_EX2DR   : TAP_PAUSEDR;
            TAP_EX2DR:   n = tms ? TAP_UPDDR   : TAP_SHDR;
            TAP_UPDDR:   n = tms ? TAP_SELDR   : TAP_RTI;
            TAP_SELIR:   n = tms ? TAP_TLR     : TAP_CAPIR;
            TAP_CAPIR:   n = tms ? TAP_EX1IR   : TAP_SHIR;
            TAP_SHIR:    n = tms ? TAP_EX1IR   : TAP_SHIR;
            TAP_EX1IR:   n = tms ? TAP_UPDIR   : TAP_PAUSEIR;
            TAP_PAUSEIR: n = tms ? TAP_EX2IR   : TAP_PAUSEIR;
            TAP_EX2IR:   n = tms ? TAP_UPDIR   : TAP_SHIR;
            TAP_UPDIR:   n = tms ? TAP_SELDR   : TAP_RTI;
            default:     n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ux607_jtag_sync.sv
// N-stage flop synchronizer for one asynchronous pin-port signal.
module ux607_jtag_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = d;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ux607_jtag_tap_ctrl.sv
// JTAG TAP controller clocked by the system clock: TCK is oversampled and its
// edges become single-cycle strobes that step the TAP FSM and shift registers.
module ux607_jtag_tap_ctrl
    import ux607_jtag_pkg::*;
#(
    parameter int              IR_W        = 5,
    parameter logic [31:0]     IDCODE_VAL  = JTAG_IDCODE_VAL,
    parameter logic [IR_W-1:0] IR_IDCODE   = JTAG_IR_IDCODE,
    parameter logic [IR_W-1:0] IR_USER     = JTAG_IR_USER,
    parameter int              USER_W      = 32,
    parameter int              SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              jtag_tck,
    input  logic              jtag_tms,
    input  logic              jtag_tdi,
    input  logic              jtag_trst,
    output logic              jtag_tdo,
    output logic              jtag_drv_tdo,
    output logic [3:0]        tap_state,
    output logic [IR_W-1:0]   ir_q,
    output logic              user_capture,
    input  logic [USER_W-1:0] user_capture_data,
    output logic              user_update,
    output logic [USER_W-1:0] user_update_data
);

    localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-2){1'b0}}, 2'b01};

    logic tck_s, tms_s, tdi_s, trst_s;
    logic tck_hist_q;
    logic tck_rise, tck_fall;

    ux607_jtag_sync #(.STAGES(SYNC_STAGES)) u_sync_tck  (.clock(clock), .rst_n(rst_n), .d(jtag_tck),  .q(tck_s));
    ux607_jtag_sync #(.STAGES(SYNC_STAGES)) u_sync_tms  (.clock(clock), .rst_n(rst_n), .d(jtag_tms),  .q(tms_s));
    ux607_jtag_sync #(.STAGES(SYNC_STAGES)) u_sync_tdi  (.clock(clock), .rst_n(rst_n), .d(jtag_tdi),  .q(tdi_s));
    ux607_jtag_sync #(.STAGES(SYNC_STAGES)) u_sync_trst (.clock(clock), .rst_n(rst_n), .d(jtag_trst), .q(trst_s));

    assign tck_rise = tck_s & ~tck_hist_q;
    assign tck_fall = ~tck_s & tck_hist_q;

    tap_state_e        state_q, state_d;
    logic [IR_W-1:0]   ir_d;
    logic [IR_W-1:0]   ir_shift_q, ir_shift_d;
    logic [31:0]       idcode_shift_q, idcode_shift_d;
    logic              bypass_q, bypass_d;
    logic [USER_W-1:0] user_shift_q, user_shift_d;
    logic [USER_W-1:0] user_update_data_q, user_update_data_d;
    logic              tdo_q, tdo_d;
    logic              drv_q, drv_d;
    logic              cap_q, cap_d;
    logic              upd_q, upd_d;
    dr_sel_e           dr_sel;
    logic              dr_lsb;

    always_comb begin
        if (ir_q == IR_IDCODE)    dr_sel = DR_IDCODE;
        else if (ir_q == IR_USER) dr_sel = DR_USER;
        else                      dr_sel = DR_BYPASS;
        case (dr_sel)
            DR_IDCODE: dr_lsb = idcode_shift_q[0];
            DR_USER:   dr_lsb = user_shift_q[0];
            default:   dr_lsb = bypass_q;
        endcase
    end

    always_comb begin
        state_d            = state_q;
        ir_d               = ir_q;
        ir_shift_d         = ir_shift_q;
        idcode_shift_d     = idcode_shift_q;
        bypass_d           = bypass_q;
        user_shift_d       = user_shift_q;
        user_update_data_d = user_update_data_q;
        tdo_d              = tdo_q;
        drv_d              = drv_q;
        cap_d              = 1'b0;
        upd_d              = 1'b0;

        // TRST has priority over any TCK strobe in the same clock
        if (trst_s) begin
            state_d = TAP_TLR;
            ir_d    = IR_IDCODE;
        end else if (tck_rise) begin
            state_d = tap_next(state_q, tms_s);
            if (state_d == TAP_TLR) ir_d = IR_IDCODE;
            case (state_q)
                TAP_CAPIR: ir_shift_d = IR_CAPTURE;
                TAP_SHIR:  ir_shift_d = {tdi_s, ir_shift_q[IR_W-1:1]};
                TAP_CAPDR: begin
                    case (dr_sel)
                        DR_IDCODE: idcode_shift_d = IDCODE_VAL;
                        DR_USER: begin
                            user_shift_d = user_capture_data;
                            cap_d        = 1'b1;
                        end
                        default:   bypass_d = 1'b0;
                    endcase
                end
                TAP_SHDR: begin
                    case (dr_sel)
                        DR_IDCODE: idcode_shift_d = {tdi_s, idcode_shift_q[31:1]};
                        DR_USER:   user_shift_d   = {tdi_s, user_shift_q[USER_W-1:1]};
                        default:   bypass_d       = tdi_s;
                    endcase
                end
                default: ;
            endcase
        end else if (tck_fall) begin
            drv_d = (state_q == TAP_SHIR) || (state_q == TAP_SHDR);
            if (state_q == TAP_SHIR)      tdo_d = ir_shift_q[0];
            else if (state_q == TAP_SHDR) tdo_d = dr_lsb;
            if (state_q == TAP_UPDIR) ir_d = ir_shift_q;
            if (state_q == TAP_UPDDR && ir_q == IR_USER) begin
                user_update_data_d = user_shift_q;
                upd_d              = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tck_hist_q         <= 1'b0;
            state_q            <= TAP_TLR;
            ir_q               <= IR_IDCODE;
            ir_shift_q         <= '0;
            idcode_shift_q     <= '0;
            bypass_q           <= 1'b0;
            user_shift_q       <= '0;
            user_update_data_q <= '0;
            tdo_q              <= 1'b0;
            drv_q              <= 1'b0;
            cap_q              <= 1'b0;
            upd_q              <= 1'b0;
        end else begin
            tck_hist_q         <= tck_s;
            state_q            <= state_d;
            ir_q               <= ir_d;
            ir_shift_q         <= ir_shift_d;
            idcode_shift_q     <= idcode_shift_d;
            bypass_q           <= bypass_d;
            user_shift_q       <= user_shift_d;
            user_update_data_q <= user_update_data_d;
            tdo_q              <= tdo_d;
            drv_q              <= drv_d;
            cap_q              <= cap_d;
            upd_q              <= upd_d;
        end
    end

    assign tap_state        = state_q;
    assign jtag_tdo         = tdo_q;
    assign jtag_drv_tdo     = drv_q;
    assign user_capture     = cap_q;
    assign user_update      = upd_q;
    assign user_update_data = user_update_data_q;

endmodule

// File: tb/tb_ux607_jtag_tap_ctrl.sv
// Directed bench for the TAP controller: TDO expectations go into a scoreboard
// queue as each shift is set up and are popped as the bits appear.
`timescale 1ns/1ps
module tb_ux607_jtag_tap_ctrl;

    logic        clock;
    logic        rst_n;
    logic        jtag_tck, jtag_tms, jtag_tdi, jtag_trst;
    logic        jtag_tdo, jtag_drv_tdo;
    logic [3:0]  tap_state;
    logic [4:0]  ir_q;
    logic        user_capture, user_update;
    logic [31:0] user_capture_data, user_update_data;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        exp_q[$];
    int          cap_cnt = 0;
    int          upd_cnt = 0;
    logic [31:0] upd_seen = '0;

    ux607_jtag_tap_ctrl dut (
        .clock(clock), .rst_n(rst_n),
        .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_trst(jtag_trst),
        .jtag_tdo(jtag_tdo), .jtag_drv_tdo(jtag_drv_tdo),
        .tap_state(tap_state), .ir_q(ir_q),
        .user_capture(user_capture), .user_capture_data(user_capture_data),
        .user_update(user_update), .user_update_data(user_update_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (user_capture) cap_cnt <= cap_cnt + 1;
        if (user_update) begin
            upd_cnt  <= upd_cnt + 1;
            upd_seen <= user_update_data;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one TCK period: rise with the given TMS/TDI, then fall; ends after the fall is seen
    task automatic step(input logic tms, input logic tdi);
        @(negedge clock);
        jtag_tms = tms;
        jtag_tdi = tdi;
        repeat (2) @(negedge clock);
        jtag_tck = 1'b1;
        repeat (5) @(negedge clock);
        jtag_tck = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    task automatic push_word(input int n, input logic [31:0] w);
        for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
    endtask

    // called in a shift state; last bit leaves with TMS=1 into Exit1
    task automatic shift(input int n, input logic [31:0] din, input string tag, output logic [31:0] dout);
        logic e;
        dout = '0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_drv"}, {31'b0, jtag_drv_tdo}, 32'd1);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL %s_sb: observed empty queue expected entry", tag);
            end else begin
                e = exp_q.pop_front();
                chk(tag, {31'b0, jtag_tdo}, {31'b0, e});
            end
            dout[i] = jtag_tdo;
            step(i == n - 1, din[i]);
        end
    endtask

    // from RTI: program the IR and return to RTI
    task automatic load_ir(input logic [4:0] val);
        logic [31:0] d;
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        push_word(5, 32'h1);
        shift(5, {27'b0, val}, "ir_cap", d);
        step(1, 0);
        step(0, 0);
    endtask

    initial begin
        logic [31:0] dout;
        int c0, u0;
        rst_n = 1'b0;
        jtag_tck = 0; jtag_tms = 0; jtag_tdi = 0; jtag_trst = 0;
        user_capture_data = 32'hA5A5_0F0F;
        repeat (3) @(negedge clock);
        chk("rst_state", {28'b0, tap_state}, 32'hF);
        chk("rst_ir", {27'b0, ir_q}, 32'h01);
        chk("rst_tdo", {31'b0, jtag_tdo}, 32'd0);
        chk("rst_drv", {31'b0, jtag_drv_tdo}, 32'd0);
        chk("rst_cap", {31'b0, user_capture}, 32'd0);
        chk("rst_upd", {31'b0, user_update}, 32'd0);
        rst_n = 1'b1;

        // IR read: capture pattern 00001 comes out while shifting ones in
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("tlr", {28'b0, tap_state}, 32'hF);
        step(0, 0); step(1, 0); step(1, 0); step(0, 0);
        chk("capir_state", {28'b0, tap_state}, 32'hE);
        chk("capir_drv", {31'b0, jtag_drv_tdo}, 32'd0);
        step(0, 0);
        chk("shir_state", {28'b0, tap_state}, 32'hA);
        push_word(5, 32'h1);
        shift(5, 32'h1F, "ir_read", dout);
        chk("ex1ir_state", {28'b0, tap_state}, 32'h9);
        chk("ex1ir_drv", {31'b0, jtag_drv_tdo}, 32'd0);
        step(1, 0);
        chk("updir_ir", {27'b0, ir_q}, 32'h1F);

        // IDCODE read after returning through TLR
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("tlr_ir", {27'b0, ir_q}, 32'h01);
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        chk("shdr_state", {28'b0, tap_state}, 32'h2);
        push_word(32, 32'h1E20_0A6D);
        shift(32, 32'h0, "idcode_bit", dout);
        chk("idcode_word", dout, 32'h1E20_0A6D);
        step(1, 0); step(0, 0);

        // BYPASS: one-TCK delay with leading zero
        load_ir(5'h1F);
        chk("bypass_ir", {27'b0, ir_q}, 32'h1F);
        step(1, 0); step(0, 0); step(0, 0);
        push_word(4, 32'b1010);
        shift(4, 32'b1101, "bypass", dout);
        step(1, 0); step(0, 0);

        // USER DR capture / shift / update
        load_ir(5'h10);
        chk("user_ir", {27'b0, ir_q}, 32'h10);
        c0 = cap_cnt; u0 = upd_cnt;
        step(1, 0); step(0, 0); step(0, 0);
        chk("user_cap_pulse", cap_cnt - c0, 32'd1);
        push_word(32, 32'hA5A5_0F0F);
        shift(32, 32'h1234_5678, "user_bit", dout);
        chk("user_tdo_word", dout, 32'hA5A5_0F0F);
        chk("user_no_early_upd", upd_cnt - u0, 32'd0);
        step(1, 0);
        chk("user_upd_pulse", upd_cnt - u0, 32'd1);
        chk("user_upd_data", upd_seen, 32'h1234_5678);
        chk("user_upd_port", user_update_data, 32'h1234_5678);
        step(0, 0);
        chk("user_cap_once", cap_cnt - c0, 32'd1);

        // TRST in the middle of a USER shift
        step(1, 0); step(0, 0); step(0, 0);
        step(0, 1); step(0, 1);
        chk("trst_pre_drv", {31'b0, jtag_drv_tdo}, 32'd1);
        u0 = upd_cnt;
        jtag_trst = 1'b1;
        repeat (4) @(negedge clock);
        chk("trst_state", {28'b0, tap_state}, 32'hF);
        chk("trst_ir", {27'b0, ir_q}, 32'h01);
        step(0, 0);
        chk("trst_hold", {28'b0, tap_state}, 32'hF);
        jtag_trst = 1'b0;
        repeat (4) @(negedge clock);
        step(1, 0);
        chk("trst_drv_off", {31'b0, jtag_drv_tdo}, 32'd0);
        chk("trst_no_upd", upd_cnt - u0, 32'd0);

        // asynchronous reset in the middle of ShIR
        step(0, 0);
        load_ir(5'h1F);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        chk("pre_arst_drv", {31'b0, jtag_drv_tdo}, 32'd1);
        chk("pre_arst_tdo", {31'b0, jtag_tdo}, 32'd1);
        step(0, 1);
        @(negedge clock);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", {28'b0, tap_state}, 32'hF);
        chk("arst_ir", {27'b0, ir_q}, 32'h01);
        chk("arst_tdo", {31'b0, jtag_tdo}, 32'd0);
        chk("arst_drv", {31'b0, jtag_drv_tdo}, 32'd0);
        chk("arst_cap", {31'b0, user_capture}, 32'd0);
        chk("arst_upd", {31'b0, user_update}, 32'd0);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        repeat (2) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
